// File: rtl/fp_add_align_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_align_unit
//  Description : DLFloat16 add/subtract front end. Captures two operands,
//                aligns the smaller significand (with sticky collection),
//                adds or subtracts, normalizes and presents an unrounded
//                20-bit result {sign, exp[5:0], mant[8:0], ext[3:0]} for a
//                downstream rounding stage. One operation in flight at a time.
//
//  Ports       : clk       - clock, rising edge
//                rst       - asynchronous active-high reset
//                in_valid  - operands a/b/sub presented
//                in_ready  - block can accept an operation (IDLE only)
//                a, b      - DLFloat16 operands {sign, exp bias 31, mant}
//                sub       - 1: a-b, 0: a+b
//                out_valid - out holds a result (DONE state)
//                out_ready - downstream consumes out
//                out       - {sign, exp, mant, guard, round, third, sticky}
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_add_align_unit #(
    parameter int EXT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          a,
    input  logic [15:0]          b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15+EXT_W:0]    out
);

    // Significand: hidden bit + 9-bit mantissa + extension bits.
    localparam int c_SIG_W = 10 + EXT_W;
    localparam logic [c_SIG_W-1:0] c_SIG_ONES = '1;
    localparam logic [15+EXT_W:0]  c_NAN_OUT  = {1'b0, 6'h3F, 9'h1FF, {EXT_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_in_ready;
    logic   w_accept;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign w_accept = in_valid && r_in_ready;

    // in_ready is registered so it stays low throughout reset and rises
    // only on the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == S_IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        out_valid    = 1'b0;
        in_ready     = r_in_ready;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ALIGN;
            S_ALIGN: w_state_next = S_ADD;
            S_ADD:   w_state_next = S_NORM;
            S_NORM:  w_state_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture (only on an accepted transfer)
    // ------------------------------------------------------------------
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_sub;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_sub <= sub;
        end
    end

    // ------------------------------------------------------------------
    // ALIGN: classify, order by magnitude, shift smaller with sticky
    // ------------------------------------------------------------------
    logic [5:0]         w_exp_a, w_exp_b, w_exp_l, w_exp_s, w_diff;
    logic               w_zero_a, w_zero_b, w_nan;
    logic               w_sign_a, w_sign_b, w_sign_l, w_swap;
    logic [14:0]        w_key_a, w_key_b;
    logic [c_SIG_W-1:0] w_sig_a, w_sig_b, w_sig_l, w_sig_s, w_sig_sh;

    assign w_exp_a  = r_a[14:9];
    assign w_exp_b  = r_b[14:9];
    assign w_zero_a = (w_exp_a == 6'd0);
    assign w_zero_b = (w_exp_b == 6'd0);
    assign w_nan    = ((w_exp_a == 6'h3F) && (r_a[8:0] == 9'h1FF)) ||
                      ((w_exp_b == 6'h3F) && (r_b[8:0] == 9'h1FF));
    assign w_sign_a = r_a[15];
    // b enters the datapath already negated for subtraction.
    assign w_sign_b = r_b[15] ^ r_sub;

    // Flushed zeros compare as magnitude 0 whatever their mantissa holds;
    // a zero operand then falls through the datapath unchanged as +0.
    assign w_key_a = w_zero_a ? 15'd0 : r_a[14:0];
    assign w_key_b = w_zero_b ? 15'd0 : r_b[14:0];
    assign w_swap  = (w_key_b > w_key_a);

    assign w_sig_a = w_zero_a ? '0 : {1'b1, r_a[8:0], {EXT_W{1'b0}}};
    assign w_sig_b = w_zero_b ? '0 : {1'b1, r_b[8:0], {EXT_W{1'b0}}};

    assign w_sig_l  = w_swap ? w_sig_b  : w_sig_a;
    assign w_sig_s  = w_swap ? w_sig_a  : w_sig_b;
    assign w_exp_l  = w_swap ? w_exp_b  : w_exp_a;
    assign w_exp_s  = w_swap ? w_exp_a  : w_exp_b;
    assign w_sign_l = w_swap ? w_sign_b : w_sign_a;
    assign w_diff   = w_exp_l - w_exp_s;

    always_comb begin
        w_sig_sh = '0;
        if (w_diff >= 6'(c_SIG_W)) begin
            // Everything shifts out: only the sticky survives.
            w_sig_sh[0] = |w_sig_s;
        end else begin
            w_sig_sh    = w_sig_s >> w_diff;
            w_sig_sh[0] = w_sig_sh[0] | (|(w_sig_s & ~(c_SIG_ONES << w_diff)));
        end
    end

    logic [c_SIG_W-1:0] r_al_sig_l, r_al_sig_s;
    logic [5:0]         r_al_exp;
    logic               r_al_sign, r_al_eff_sub, r_al_nan;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_al_sig_l   <= '0;
            r_al_sig_s   <= '0;
            r_al_exp     <= '0;
            r_al_sign    <= 1'b0;
            r_al_eff_sub <= 1'b0;
            r_al_nan     <= 1'b0;
        end else if (r_state == S_ALIGN) begin
            r_al_sig_l   <= w_sig_l;
            r_al_sig_s   <= w_sig_sh;
            r_al_exp     <= w_exp_l;
            r_al_sign    <= w_sign_l;
            r_al_eff_sub <= w_sign_a ^ w_sign_b;
            r_al_nan     <= w_nan;
        end
    end

    // ------------------------------------------------------------------
    // ADD: larger minus/plus smaller; ordering keeps subtraction >= 0
    // ------------------------------------------------------------------
    logic [c_SIG_W:0] w_sum;
    logic [c_SIG_W:0] r_ad_sum;
    logic [5:0]       r_ad_exp;
    logic             r_ad_sign, r_ad_nan;

    assign w_sum = r_al_eff_sub ? ({1'b0, r_al_sig_l} - {1'b0, r_al_sig_s})
                                : ({1'b0, r_al_sig_l} + {1'b0, r_al_sig_s});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ad_sum  <= '0;
            r_ad_exp  <= '0;
            r_ad_sign <= 1'b0;
            r_ad_nan  <= 1'b0;
        end else if (r_state == S_ADD) begin
            r_ad_sum  <= w_sum;
            r_ad_exp  <= r_al_exp;
            r_ad_sign <= r_al_sign;
            r_ad_nan  <= r_al_nan;
        end
    end

    // ------------------------------------------------------------------
    // NORM: carry shift-right or leading-zero shift-left, then range check
    // ------------------------------------------------------------------
    logic [3:0]          w_lz;
    logic [c_SIG_W-1:0]  w_norm;
    logic signed [7:0]   w_exp_n;
    logic [15+EXT_W:0]   w_result;
    logic [15+EXT_W:0]   r_out;

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        w_lz = 4'd0;
        for (int i = 0; i < c_SIG_W; i++) begin
            if (r_ad_sum[i]) w_lz = 4'(c_SIG_W - 1 - i);
        end
    end

    always_comb begin
        w_norm  = '0;
        w_exp_n = '0;
        if (r_ad_sum[c_SIG_W]) begin
            w_norm    = r_ad_sum[c_SIG_W:1];
            w_norm[0] = r_ad_sum[1] | r_ad_sum[0];
            w_exp_n   = $signed({2'b00, r_ad_exp}) + 8'sd1;
        end else begin
            w_norm    = r_ad_sum[c_SIG_W-1:0] << w_lz;
            w_exp_n   = $signed({2'b00, r_ad_exp}) - $signed({4'b0000, w_lz});
        end
    end

    always_comb begin
        w_result = {r_ad_sign, w_exp_n[5:0], w_norm[c_SIG_W-2:0]};
        if (r_ad_nan) begin
            w_result = c_NAN_OUT;
        end else if (r_ad_sum == '0) begin
            w_result = '0;
        end else if ((w_exp_n > 8'sd63) ||
                     ((w_exp_n == 8'sd63) && (&w_norm[c_SIG_W-2:EXT_W]) &&
                      (|w_norm[EXT_W-1:0]))) begin
            w_result = {r_ad_sign, 6'h3F, 9'h1FF, {EXT_W{1'b0}}};
        end else if (w_exp_n < 8'sd1) begin
            w_result = {r_ad_sign, {(15+EXT_W){1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (r_state == S_NORM) begin
            r_out <= w_result;
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire
